// File: rtl/csa_seq_ctrl.sv
// csa_seq_ctrl: multi-cycle sequencer that adds two WIDTH-bit operands one
// SIZE-bit chunk per clock, LSB chunk first, through a registered carry.
// Valid/ready handshakes on both the operand and the result side.
// Optional macro ZERO_SKIP_EN: when the remaining upper part of B is zero,
// finish the upper bits in one cycle with an AND-chain incrementer.
module csa_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / SIZE;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if ((SIZE < 1) || ((WIDTH % SIZE) != 0)) begin : g_bad_param
      $error("csa_seq_ctrl: WIDTH must be a positive multiple of SIZE");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;

  logic [SIZE-1:0]   a_ch_s;
  logic [SIZE-1:0]   b_ch_s;
  logic [SIZE:0]     chunk_sum_s;

`ifdef ZERO_SKIP_EN
  logic              skip_s;
  logic [WIDTH-1:0]  skip_sum_s;
  logic              skip_cout_s;
`endif

  // Select the operand chunks addressed by the index and add them with the carry.
  always_comb begin
    a_ch_s = {SIZE{1'b0}};
    b_ch_s = {SIZE{1'b0}};
    for (int k = 0; k < NCHUNK; k++) begin
      if (idx_q == IDXW'(k)) begin
        a_ch_s = a_q[k*SIZE +: SIZE];
        b_ch_s = b_q[k*SIZE +: SIZE];
      end else begin
        a_ch_s = a_ch_s;
        b_ch_s = b_ch_s;
      end
    end
    chunk_sum_s = {1'b0, a_ch_s} + {1'b0, b_ch_s} + {{SIZE{1'b0}}, carry_q};
  end

`ifdef ZERO_SKIP_EN
  // Detect an all-zero upper B and precompute the incremented upper A bits.
  always_comb begin
    logic chain;
    chain       = 1'b0;
    skip_s      = 1'b0;
    skip_sum_s  = sum_q;
    skip_cout_s = 1'b0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (idx_q == IDXW'(k)) begin
        skip_s = ((b_q >> (k*SIZE)) == {WIDTH{1'b0}});
        chain  = carry_q;
        for (int i = k*SIZE; i < WIDTH; i++) begin
          skip_sum_s[i] = a_q[i] ^ chain;
          chain         = chain & a_q[i];
        end
        skip_cout_s = chain;
      end else begin
        skip_s = skip_s;
      end
    end
  end
`endif

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = {IDXW{1'b0}};
          sum_d   = {WIDTH{1'b0}};
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        for (int k = 0; k < NCHUNK; k++) begin
          if (idx_q == IDXW'(k)) begin
            sum_d[k*SIZE +: SIZE] = chunk_sum_s[SIZE-1:0];
          end else begin
            sum_d[k*SIZE +: SIZE] = sum_d[k*SIZE +: SIZE];
          end
        end
        carry_d = chunk_sum_s[SIZE];
        if (idx_q == IDXW'(NCHUNK-1)) begin
          cout_d  = chunk_sum_s[SIZE];
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
`ifdef ZERO_SKIP_EN
        if (skip_s) begin
          sum_d   = skip_sum_s;
          cout_d  = skip_cout_s;
          state_d = DONE;
        end else begin
          state_d = state_d;
        end
`endif
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, operand and result registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= {IDXW{1'b0}};
      carry_q <= 1'b0;
      sum_q   <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_csa_seq_ctrl.sv
// Self-checking bench for csa_seq_ctrl (WIDTH=32, SIZE=4): table-driven
// vectors through a scoreboard queue, plus backpressure and mid-run reset.
module tb_csa_seq_ctrl;

  localparam int WIDTH  = 32;
  localparam int SIZE   = 4;
  localparam int NCHUNK = WIDTH / SIZE;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  csa_seq_ctrl #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;
    int               hold;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    int               lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_total;
  int   n_pass;

  // Record one comparison; print a FAIL line when it does not match.
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected latency from accept edge to out_valid, in cycles.
  function automatic int model_lat(input logic [WIDTH-1:0] bv);
`ifdef ZERO_SKIP_EN
    for (int k = 0; k < NCHUNK; k++) begin
      if ((bv >> (k*SIZE)) == {WIDTH{1'b0}}) return k + 1;
    end
    return NCHUNK;
`else
    return NCHUNK;
`endif
  endfunction

  // Offer operands, wait for accept, then wait for and score the result.
  task automatic do_txn(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic cv, input logic [WIDTH-1:0] es, input logic ec,
                        input int hold);
    exp_t e;
    exp_t got;
    bit   acc;
    int   lat;
    int   waits;
    out_ready = (hold == 0);
    @(negedge clk);
    a = av; b = bv; cin = cv; in_valid = 1'b1;
    acc = 1'b0;
    waits = 0;
    while (!acc && waits < 50) begin
      acc = in_ready;
      @(posedge clk);
      waits++;
    end
    chk("accept", {63'd0, acc}, 64'd1);
    e.sum = es; e.cout = ec; e.lat = model_lat(bv);
    sb_q.push_back(e);
    #1;
    in_valid = 1'b0;
    a = ~av; b = ~bv; cin = ~cv;
    lat = 0;
    while (lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
    chk("out_valid_seen", {63'd0, out_valid}, 64'd1);
    if (sb_q.size() == 0) begin
      chk("scoreboard_nonempty", 64'd0, 64'd1);
    end else begin
      got = sb_q.pop_front();
      chk("latency", 64'(lat), 64'(got.lat));
      chk("sum", {32'd0, sum}, {32'd0, got.sum});
      chk("cout", {63'd0, cout}, {63'd0, got.cout});
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'b1;
        a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; cin = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        chk("bp_sum", {32'd0, sum}, {32'd0, got.sum});
        chk("bp_cout", {63'd0, cout}, {63'd0, got.cout});
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("drop_out_valid", {63'd0, out_valid}, 64'd0);
      chk("idle_in_ready", {63'd0, in_ready}, 64'd1);
      chk("idle_busy", {63'd0, busy}, 64'd0);
    end
  endtask

  vec_t vecs[8];

  initial begin
    logic [WIDTH:0] full;
    int ov_cnt;
    n_total = 0;
    n_pass  = 0;

    vecs[0] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 0};
    vecs[2] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 0};
    vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 5};
    vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0001, 1'b1, 0};
    vecs[5] = '{32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, 32'h0000_0000, 1'b1, 0};
    vecs[6] = '{32'hFFFF_FFFF, 32'h1000_0000, 1'b0, 32'h0FFF_FFFF, 1'b1, 0};
    vecs[7] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = 32'd0; b = 32'd0; cin = 1'b0;
    #12;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_sum", {32'd0, sum}, 64'd0);
    chk("rst_cout", {63'd0, cout}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_out_valid", {63'd0, out_valid}, 64'd0);

    for (int i = 0; i < 8; i++) begin
      do_txn(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].hold);
    end

    for (int i = 0; i < 6; i++) begin
      logic [WIDTH-1:0] ra, rb;
      logic rc;
      ra = $urandom;
      rb = (i == 3) ? (32'h0000_00FF & $urandom) : $urandom;
      rc = 1'($urandom_range(1, 0));
      full = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc};
      do_txn(ra, rb, rc, full[WIDTH-1:0], full[WIDTH], 0);
    end

    // Reset during the third RUN cycle discards the in-flight result.
    @(negedge clk);
    a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_sum", {32'd0, sum}, 64'd0);
    chk("midrst_cout", {63'd0, cout}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    ov_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) ov_cnt++;
    end
    chk("midrst_no_result", 64'(ov_cnt), 64'd0);
    do_txn(32'd1, 32'd1, 1'b1, 32'd3, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
